// File: rtl/riscv_imm_pkg.sv
// Shared definitions for the RISC-V immediate generator: opcodes, format codes and the
// XLEN legality check.
package riscv_imm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FmtNone = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtZ    = 3'd6
    } imm_fmt_e;

    function automatic bit xlen_legal(int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out channel pair of the immediate generator stage.
interface imm_gen_pipe_if
    import riscv_imm_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    imm_fmt_e         out_fmt;
    logic             out_legal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_legal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_legal, out_tag
    );
endinterface

// File: rtl/imm_extract.sv
// Combinational immediate decode: instruction word -> extended immediate, format, legality.
module imm_extract
    import riscv_imm_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            legal
);
    logic [31:0] val;
    logic        unused_funct3;

    assign unused_funct3 = ^instr[13:12];

    // Every format is first built as a 32-bit value; Z has bit 31 clear, so a single
    // sign extension to XLEN covers both sext and zext cases.
    always_comb begin
        val   = '0;
        fmt   = FmtNone;
        legal = 1'b1;
        case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                fmt = FmtI;
                val = {{20{instr[31]}}, instr[31:20]};
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    fmt = FmtI;
                    val = {{20{instr[31]}}, instr[31:20]};
                end else begin
                    legal = 1'b0;
                end
            end
            OP_STORE: begin
                fmt = FmtS;
                val = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt = FmtB;
                val = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt = FmtU;
                val = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt = FmtJ;
                val = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_SYSTEM: begin
                if (instr[14]) begin
                    fmt = FmtZ;
                    val = {27'b0, instr[19:15]};
                end
            end
            default: legal = 1'b0;
        endcase
    end

    assign imm = XLEN'($signed(val));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator stage with a one-entry skid buffer for full throughput
// under backpressure while keeping in_ready a flop output.
module imm_gen_pipe
    import riscv_imm_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 64
) (
    input logic           clk,
    input logic           rst_n,
    imm_gen_pipe_if.slave bus
);
    if (!xlen_legal(XLEN)) begin : gen_xlen_check
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             legal;
        logic [TAG_W-1:0] tag;
    } result_t;

    result_t         in_res;
    result_t         out_q;
    result_t         skid_q;
    logic            out_valid_q;
    logic            skid_valid_q;
    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_legal;
    logic            in_fire;
    logic            out_free;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instr(bus.in_instr),
        .imm  (dec_imm),
        .fmt  (dec_fmt),
        .legal(dec_legal)
    );

    always_comb begin
        in_res.imm   = dec_imm;
        in_res.fmt   = dec_fmt;
        in_res.legal = dec_legal;
        in_res.tag   = bus.in_tag;
    end

    assign in_fire  = bus.in_valid && !skid_valid_q;
    assign out_free = !out_valid_q || bus.out_ready;

    // The skid only fills while the output is stalled, and in_ready is low while it is full,
    // so it never needs to accept and drain in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (in_fire) begin
                out_q       <= in_res;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q       <= in_res;
            skid_valid_q <= 1'b1;
        end
    end

    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_q.imm;
    assign bus.out_fmt   = out_q.fmt;
    assign bus.out_legal = out_q.legal;
    assign bus.out_tag   = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: XLEN=64 and XLEN=32 instances fed the same stream and backpressure.
module tb_imm_gen_pipe;
    import riscv_imm_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm64;
        logic [31:0] imm32;
        imm_fmt_e    fmt64;
        imm_fmt_e    fmt32;
        logic        legal64;
        logic        legal32;
        logic [63:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [63:0] in_tag = '0;
    logic        out_ready = 1'b1;

    int   total = 0;
    int   bad = 0;
    int   n_in = 0;
    int   rdy_mode = 0;
    exp_t vecs[$];
    exp_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(64), .TAG_W(64)) bus64 ();
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(64)) bus32 ();

    assign bus64.in_valid  = in_valid;
    assign bus64.in_instr  = in_instr;
    assign bus64.in_tag    = in_tag;
    assign bus64.out_ready = out_ready;
    assign bus32.in_valid  = in_valid;
    assign bus32.in_instr  = in_instr;
    assign bus32.in_tag    = in_tag;
    assign bus32.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(64), .TAG_W(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
    imm_gen_pipe #(.XLEN(32), .TAG_W(64)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(logic [31:0] instr, logic [63:0] i64, logic [31:0] i32,
                                imm_fmt_e f64, imm_fmt_e f32, logic l64, logic l32);
        exp_t e;
        e.instr = instr; e.imm64 = i64; e.imm32 = i32;
        e.fmt64 = f64; e.fmt32 = f32; e.legal64 = l64; e.legal32 = l32; e.tag = '0;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input int idx);
        exp_t e;
        logic accepted;
        e = vecs[idx];
        e.tag = {$urandom, $urandom};
        in_valid = 1'b1;
        in_instr = e.instr;
        in_tag = e.tag;
        accepted = 1'b0;
        for (int c = 0; c < 100 && !accepted; c++) begin
            if (bus64.in_ready) begin
                q.push_back(e);
                n_in++;
                accepted = 1'b1;
            end
            @(negedge clk);
        end
        check("accept", 64'(accepted), 64'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && q.size() != 0; c++) @(negedge clk);
        check("drain", 64'(q.size()), 64'd0);
    endtask

    // Monitor: occupancy model, stall stability and scoreboard compare.
    initial begin
        int n_out, in_snap, out_snap, occ;
        logic st64, st32;
        logic [131:0] sv64;
        logic [99:0] sv32;
        exp_t e;
        n_out = 0; in_snap = 0; out_snap = 0; st64 = 0; st32 = 0; sv64 = '0; sv32 = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                n_out = 0; in_snap = 0; out_snap = 0; st64 = 0; st32 = 0;
                continue;
            end
            occ = in_snap - out_snap;
            check("in_ready64", 64'(bus64.in_ready), 64'(occ != 2));
            check("in_ready32", 64'(bus32.in_ready), 64'(occ != 2));
            check("out_valid64", 64'(bus64.out_valid), 64'(occ != 0));
            check("out_valid32", 64'(bus32.out_valid), 64'(occ != 0));
            if (st64)
                check("stable64", 64'({bus64.out_imm, bus64.out_fmt, bus64.out_legal,
                                       bus64.out_tag} == sv64), 64'd1);
            if (st32)
                check("stable32", 64'({bus32.out_imm, bus32.out_fmt, bus32.out_legal,
                                       bus32.out_tag} == sv32), 64'd1);
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if ((bus64.out_valid || bus32.out_valid) && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", 64'(q.size()), 64'd1);
                end else begin
                    e = q[0];
                    if (bus64.out_valid) begin
                        check("imm64", bus64.out_imm, e.imm64);
                        check("fmt64", 64'(bus64.out_fmt), 64'(e.fmt64));
                        check("legal64", 64'(bus64.out_legal), 64'(e.legal64));
                        check("tag64", bus64.out_tag, e.tag);
                    end
                    if (bus32.out_valid) begin
                        check("imm32", 64'(bus32.out_imm), 64'(e.imm32));
                        check("fmt32", 64'(bus32.out_fmt), 64'(e.fmt32));
                        check("legal32", 64'(bus32.out_legal), 64'(e.legal32));
                        check("tag32", bus32.out_tag, e.tag);
                    end
                    void'(q.pop_front());
                    n_out++;
                end
            end
            st64 = bus64.out_valid && !out_ready;
            st32 = bus32.out_valid && !out_ready;
            sv64 = {bus64.out_imm, bus64.out_fmt, bus64.out_legal, bus64.out_tag};
            sv32 = {bus32.out_imm, bus32.out_fmt, bus32.out_legal, bus32.out_tag};
            in_snap = n_in;
            out_snap = n_out;
        end
    end

    initial begin
        vecs.push_back(mk(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, FmtI, FmtI, 1, 1));
        vecs.push_back(mk(32'h800000B7, 64'hFFFFFFFF80000000, 32'h80000000, FmtU, FmtU, 1, 1));
        vecs.push_back(mk(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, FmtB, FmtB, 1, 1));
        vecs.push_back(mk(32'h0052D073, 64'h5, 32'h5, FmtZ, FmtZ, 1, 1));
        vecs.push_back(mk(32'h0000001B, 64'h0, 32'h0, FmtI, FmtNone, 1, 0));
        vecs.push_back(mk(32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, FmtS, FmtS, 1, 1));
        vecs.push_back(mk(32'h008000EF, 64'h8, 32'h8, FmtJ, FmtJ, 1, 1));
        vecs.push_back(mk(32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, FmtJ, FmtJ, 1, 1));
        vecs.push_back(mk(32'h30529073, 64'h0, 32'h0, FmtNone, FmtNone, 1, 1));
        vecs.push_back(mk(32'hFFFFFFFF, 64'h0, 32'h0, FmtNone, FmtNone, 0, 0));
        vecs.push_back(mk(32'h80002083, 64'hFFFFFFFFFFFFF800, 32'hFFFFF800, FmtI, FmtI, 1, 1));
        vecs.push_back(mk(32'h7FF080E7, 64'h7FF, 32'h7FF, FmtI, FmtI, 1, 1));
        vecs.push_back(mk(32'h12345017, 64'h12345000, 32'h12345000, FmtU, FmtU, 1, 1));

        #1 rst_n = 1'b0;
        #3;
        check("rst_valid64", 64'(bus64.out_valid), 64'd0);
        check("rst_valid32", 64'(bus32.out_valid), 64'd0);
        check("rst_imm64", bus64.out_imm, 64'd0);
        check("rst_imm32", 64'(bus32.out_imm), 64'd0);
        check("rst_fmt64", 64'(bus64.out_fmt), 64'(FmtNone));
        check("rst_legal64", 64'(bus64.out_legal), 64'd0);
        check("rst_tag64", bus64.out_tag, 64'd0);
        check("rst_tag32", bus32.out_tag, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Free-flowing output, then random backpressure with back-to-back input.
        rdy_mode = 0;
        for (int i = 0; i < vecs.size(); i++) send(i);
        in_valid = 1'b0;
        drain();
        rdy_mode = 1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < vecs.size(); i++) send(i);
        end
        in_valid = 1'b0;
        drain();

        // Fill output and skid under a full stall, then reset mid-operation.
        rdy_mode = 2;
        @(negedge clk);
        send(0);
        send(1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check("skid_full_ready", 64'(bus64.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("async_valid64", 64'(bus64.out_valid), 64'd0);
        check("async_valid32", 64'(bus32.out_valid), 64'd0);
        q.delete();
        n_in = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        send(6);
        in_valid = 1'b0;
        drain();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
